graphic_mode_packed: RTL and testbench

Parametrised packed-pixel graphics renderer, successor to the fixed 6-bit mode. It streams a continuous MSB-first bitstream from render VRAM, unpacks BPP-bit pixels across byte boundaries, and maps 1/2/4-bit indices through a writable 16-entry palette (6-bit direct colour for BPP=6). It scales pixels by H_SCALE×V_SCALE and places the framebuffer at a runtime base address. It sits between the VRAM render read port and the 6-bit RGB output mux, driven by the shared h/v counters.

---
 rtl/graphic_mode_packed_if.sv | 39 +++
 rtl/graphic_mode_packed.sv | 143 ++++++++++++++
 tb/tb_graphic_mode_packed.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/graphic_mode_packed_if.sv
// Bus bundle for the packed-pixel graphics renderer.
//   master : timing source / VRAM port / palette writer (drives timing, data, palette)
//   slave  : the renderer (drives render read address and rgb)
// Signals:
//   en                      mode enable
//   h_counter, v_counter    shared raster position
//   can_color               visible-area qualifier
//   vram_render_read        VRAM byte at current_vram_read_addr, 1 clk latency
//   current_vram_read_addr  render read address
//   fb_base                 framebuffer start, taken at frame wrap
//   pal_we/pal_addr/pal_data palette write port
//   rgb                     {r1,r0,g1,g0,b1,b0}
interface graphic_mode_packed_if #(
   parameter int ADDR_W = 15
);
   logic              en;
   logic [11:0]       h_counter;
   logic [11:0]       v_counter;
   logic              can_color;
   logic [7:0]        vram_render_read;
   logic [ADDR_W-1:0] current_vram_read_addr;
   logic [ADDR_W-1:0] fb_base;
   logic              pal_we;
   logic [3:0]        pal_addr;
   logic [5:0]        pal_data;
   logic [5:0]        rgb;

   modport master (
      output en, h_counter, v_counter, can_color, vram_render_read,
      output fb_base, pal_we, pal_addr, pal_data,
      input  current_vram_read_addr, rgb
   );

   modport slave (
      input  en, h_counter, v_counter, can_color, vram_render_read,
      input  fb_base, pal_we, pal_addr, pal_data,
      output current_vram_read_addr, rgb
   );
endinterface

// File: rtl/graphic_mode_packed.sv
// Packed-pixel graphics renderer.
// Streams an MSB-first bitstream from render VRAM, unpacks BPP-bit pixels
// across byte boundaries, maps 1/2/4-bit indices through a writable 16-entry
// palette (BPP=6 is direct colour), scales by H_SCALE x V_SCALE and places
// the framebuffer at a base address taken at frame wrap.
// Ports:
//   clk  single clock
//   rst  synchronous active-high reset (palette included)
//   bus  graphic_mode_packed_if.slave (timing, VRAM read port, palette port, rgb)
module graphic_mode_packed #(
   parameter int BPP           = 6,
   parameter int H_SCALE       = 4,
   parameter int V_SCALE       = 4,
   parameter int ACTIVE_PIXELS = 200,
   parameter int ADDR_W        = 15,
   parameter int LEAD          = 4,
   parameter int WHOLE_LINE    = 800,
   parameter int WHOLE_FRAME   = 525
) (
   input logic                  clk,
   input logic                  rst,
   graphic_mode_packed_if.slave bus
);

   if (((ACTIVE_PIXELS * BPP) % 8) != 0 ||
       !(BPP == 1 || BPP == 2 || BPP == 4 || BPP == 6) ||
       H_SCALE < 2 || V_SCALE < 1) begin : g_bad_cfg
      $error("graphic_mode_packed: illegal parameter combination");
   end

   localparam int HS_W = $clog2(H_SCALE);
   localparam int VS_W = (V_SCALE > 1) ? $clog2(V_SCALE) : 1;
   localparam logic [HS_W-1:0] H_LAST   = HS_W'(H_SCALE - 1);
   localparam logic [VS_W-1:0] V_LAST   = VS_W'(V_SCALE - 1);
   localparam logic [11:0]     LS_H     = 12'(WHOLE_LINE - LEAD);
   localparam logic [11:0]     WRAP_V   = 12'(WHOLE_FRAME - 1);
   localparam logic [14:0]     PIX_MASK = 15'((1 << BPP) - 1);

   logic [5:0]        rgb_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] line_start_q;
   logic [6:0]        bits_q;      // leftover bits, valid ones right-aligned
   logic [2:0]        cnt_q;
   logic [HS_W-1:0]   h_small_q;
   logic [VS_W-1:0]   v_small_q;
   logic [5:0]        pal_q [16];

   logic        boundary;
   logic        line_evt;
   logic        need_byte;
   logic [14:0] merged;
   logic [14:0] src;
   logic [3:0]  shift;
   logic [6:0]  next_bits;
   logic [2:0]  next_cnt;
   logic [5:0]  pix;
   logic [5:0]  colour;

   function automatic logic [5:0] pal_reset_val(input logic [3:0] i);
      if (i == 4'd0) return 6'h00;
      if (i == 4'd1) return 6'h3F;
      return {i, i[3:2]};
   endfunction

   assign boundary = bus.can_color && (h_small_q == H_LAST);
   assign line_evt = (bus.h_counter == LS_H);
   assign merged   = {bits_q, bus.vram_render_read};

   // After extracting a pixel, the bits left over are exactly those below the
   // shift point, so the shift amount doubles as the new leftover count.
   always_comb begin
      need_byte = ({1'b0, cnt_q} < 4'(BPP));
      if (need_byte) begin
         shift     = 4'({1'b0, cnt_q} + 4'd8 - 4'(BPP));
         src       = merged;
         next_bits = merged[6:0];
      end else begin
         shift     = 4'({1'b0, cnt_q} - 4'(BPP));
         src       = {8'd0, bits_q};
         next_bits = bits_q;
      end
      next_cnt = 3'(shift);
      pix      = 6'((src >> shift) & PIX_MASK);
      colour   = (BPP == 6) ? pix : pal_q[pix[3:0]];
   end

   // Lookups on the write edge read the old entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) pal_q[i] <= pal_reset_val(4'(i));
      end else if (bus.pal_we) begin
         pal_q[bus.pal_addr] <= bus.pal_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || !bus.en) begin
         rgb_q        <= '0;
         addr_q       <= '0;
         line_start_q <= '0;
         bits_q       <= '0;
         cnt_q        <= '0;
         h_small_q    <= H_LAST;
         v_small_q    <= '0;
      end else begin
         if (!bus.can_color)
            rgb_q <= '0;
         else if (boundary)
            rgb_q <= colour;

         // Line start overrides pixel-boundary updates of address/buffer/phase.
         if (line_evt) begin
            bits_q    <= '0;
            cnt_q     <= '0;
            h_small_q <= H_LAST;
            if (bus.v_counter == WRAP_V) begin
               addr_q       <= bus.fb_base;
               line_start_q <= bus.fb_base;
               v_small_q    <= '0;
            end else if (v_small_q == V_LAST) begin
               v_small_q    <= '0;
               line_start_q <= addr_q;
            end else begin
               v_small_q <= v_small_q + VS_W'(1);
               addr_q    <= line_start_q;
            end
         end else if (bus.can_color) begin
            if (boundary) begin
               h_small_q <= '0;
               bits_q    <= next_bits;
               cnt_q     <= next_cnt;
               if (need_byte) addr_q <= addr_q + ADDR_W'(1);
            end else begin
               h_small_q <= h_small_q + HS_W'(1);
            end
         end
      end
   end

   assign bus.rgb                    = rgb_q;
   assign bus.current_vram_read_addr = addr_q;

endmodule

// File: tb/tb_graphic_mode_packed.sv
// Bench for graphic_mode_packed: two instances (BPP=6 direct colour and
// BPP=2 palette) driven from one raster generator. A bit-position model
// predicts rgb and read address every cycle; literal checks pin the model.
module tb_graphic_mode_packed;
   localparam int WL   = 850;
   localparam int WF   = 10;
   localparam int LEAD = 4;
   localparam int AMOD = 32768;

   logic clk;
   logic rst;
   logic en_d;
   int   h_drv, v_drv;
   logic cc_d [2];
   logic [14:0] fb_d [2];
   logic pwe_d [2];
   logic [3:0] pa_d [2];
   logic [5:0] pd_d [2];
   logic [7:0] vram_q [2];
   logic [7:0] mem [AMOD];

   int n_cmp = 0;
   int n_bad = 0;

   graphic_mode_packed_if #(.ADDR_W(15)) b6 ();
   graphic_mode_packed_if #(.ADDR_W(15)) b2 ();

   assign b6.en = en_d;               assign b2.en = en_d;
   assign b6.h_counter = 12'(h_drv);  assign b2.h_counter = 12'(h_drv);
   assign b6.v_counter = 12'(v_drv);  assign b2.v_counter = 12'(v_drv);
   assign b6.can_color = cc_d[0];     assign b2.can_color = cc_d[1];
   assign b6.fb_base = fb_d[0];       assign b2.fb_base = fb_d[1];
   assign b6.pal_we = pwe_d[0];       assign b2.pal_we = pwe_d[1];
   assign b6.pal_addr = pa_d[0];      assign b2.pal_addr = pa_d[1];
   assign b6.pal_data = pd_d[0];      assign b2.pal_data = pd_d[1];
   assign b6.vram_render_read = vram_q[0];
   assign b2.vram_render_read = vram_q[1];

   always @(posedge clk) begin
      vram_q[0] <= mem[b6.current_vram_read_addr];
      vram_q[1] <= mem[b2.current_vram_read_addr];
   end

   graphic_mode_packed #(.BPP(6), .H_SCALE(4), .V_SCALE(4), .ACTIVE_PIXELS(200),
      .ADDR_W(15), .LEAD(LEAD), .WHOLE_LINE(WL), .WHOLE_FRAME(WF))
      u_dut6 (.clk(clk), .rst(rst), .bus(b6));

   graphic_mode_packed #(.BPP(2), .H_SCALE(2), .V_SCALE(2), .ACTIVE_PIXELS(100),
      .ADDR_W(15), .LEAD(LEAD), .WHOLE_LINE(WL), .WHOLE_FRAME(WF))
      u_dut2 (.clk(clk), .rst(rst), .bus(b2));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int bpp_c [2] = '{6, 2};
   int hs_c  [2] = '{4, 2};
   int vs_c  [2] = '{4, 2};
   int row_base [2], bitpos [2], ls [2], vsub [2], ccnt [2];
   int mpal [2][16];
   int exp_rgb [2], exp_addr [2];
   logic model_on = 1'b0;

   function automatic int pal_init(input int i);
      logic [3:0] ii;
      ii = 4'(i);
      if (i == 0) return 0;
      if (i == 1) return 63;
      return int'({ii, ii[3:2]});
   endfunction

   // n bits of the stream starting at bit bp of the row that begins at base
   function automatic int get_pix(input int base, input int bp, input int n);
      int p;
      p = 0;
      for (int i = 0; i < n; i++) begin
         int q;
         logic [7:0] b;
         q = bp + i;
         b = mem[(base + q / 8) % AMOD];
         p = p * 2 + int'(b[7 - q % 8]);
      end
      return p;
   endfunction

   task automatic clear_render(input int d);
      row_base[d] = 0; bitpos[d] = 0; ls[d] = 0; vsub[d] = 0; ccnt[d] = 0;
      exp_rgb[d] = 0;
   endtask

   task automatic model_step(input int d);
      int cur, pix;
      cur = (row_base[d] + (bitpos[d] + 7) / 8) % AMOD;
      if (rst) begin
         for (int i = 0; i < 16; i++) mpal[d][i] = pal_init(i);
         clear_render(d);
      end else begin
         if (!en_d) begin
            clear_render(d);
         end else begin
            if (cc_d[d]) begin
               if (ccnt[d] % hs_c[d] == 0) begin
                  pix = get_pix(row_base[d], bitpos[d], bpp_c[d]);
                  exp_rgb[d] = (bpp_c[d] == 6) ? pix : mpal[d][pix];
                  bitpos[d] += bpp_c[d];
               end
               ccnt[d]++;
            end else begin
               exp_rgb[d] = 0;
            end
            if (h_drv == WL - LEAD) begin
               if (v_drv == WF - 1) begin
                  ls[d] = int'(fb_d[d]); row_base[d] = int'(fb_d[d]); vsub[d] = 0;
               end else if (vsub[d] == vs_c[d] - 1) begin
                  vsub[d] = 0; ls[d] = cur; row_base[d] = cur;
               end else begin
                  vsub[d]++; row_base[d] = ls[d];
               end
               bitpos[d] = 0;
               ccnt[d] = 0;
            end
         end
         if (pwe_d[d]) mpal[d][pa_d[d]] = int'(pd_d[d]);
      end
      exp_addr[d] = (row_base[d] + (bitpos[d] + 7) / 8) % AMOD;
   endtask

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) model_step(d);
      if (rst) model_on = 1'b1;
   end

   always @(negedge clk) begin
      if (model_on) begin
         chk("rgb6",  int'(b6.rgb), exp_rgb[0]);
         chk("addr6", int'(b6.current_vram_read_addr), exp_addr[0]);
         chk("rgb2",  int'(b2.rgb), exp_rgb[1]);
         chk("addr2", int'(b2.current_vram_read_addr), exp_addr[1]);
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int h, v, frame;
      logic kill;
      int gap_left [2];
      logic g;

      for (int i = 0; i < AMOD; i++) mem[i] = 8'($urandom);
      mem[0] = 8'hFC; mem[1] = 8'h0F; mem[2] = 8'hC3; mem[3] = 8'hAA;
      mem[15'h4000] = 8'h9C; mem[15'h4001] = 8'h55;

      rst = 1'b1; en_d = 1'b1; h_drv = 0; v_drv = 0;
      for (int d = 0; d < 2; d++) begin
         cc_d[d] = 1'b0; pwe_d[d] = 1'b0; pa_d[d] = '0; pd_d[d] = '0;
         gap_left[d] = 0;
      end
      fb_d[0] = 15'h0000; fb_d[1] = 15'h4000;

      repeat (3) @(negedge clk);
      chk("reset_rgb6", int'(b6.rgb), 0);
      chk("reset_addr6", int'(b6.current_vram_read_addr), 0);
      chk("reset_rgb2", int'(b2.rgb), 0);
      chk("reset_addr2", int'(b2.current_vram_read_addr), 0);

      h = WL - LEAD; v = WF - 1; frame = -1; kill = 1'b0;
      for (int cyc = 0; cyc < LEAD + 3 * WL * WF + 5; cyc++) begin
         h_drv = h; v_drv = v;
         rst  = (frame == 1 && v == 3 && h == 400);
         en_d = !(frame == 2 && v == 3 && h == 400);
         if (h == 0) kill = 1'b0;
         if (rst || !en_d) kill = 1'b1;
         for (int d = 0; d < 2; d++) begin
            if (gap_left[d] > 0) begin
               gap_left[d]--; g = 1'b1;
            end else if (frame >= 1 && v >= 5 && $urandom_range(0, 63) == 0) begin
               gap_left[d] = 2; g = 1'b1;
            end else begin
               g = 1'b0;
            end
            cc_d[d] = (h < ((d == 0) ? 800 : 200)) && (v < 8) && !kill && !g;
         end
         pwe_d[1] = 1'b0;
         if (frame == -1) begin
            pwe_d[1] = 1'b1; pa_d[1] = 4'd2; pd_d[1] = 6'h30;
         end else if (frame == 0 && v == 0 && h == 2) begin
            pwe_d[1] = 1'b1; pa_d[1] = 4'd1; pd_d[1] = 6'h15;
         end else if (frame == 2 && v == 1 && h == 820) begin
            pwe_d[1] = 1'b1; pa_d[1] = 4'd2; pd_d[1] = 6'h21;
         end else if (frame == 1 && !(v == 3 || v == 4) && $urandom_range(0, 7) == 0) begin
            pwe_d[1] = 1'b1; pa_d[1] = 4'($urandom); pd_d[1] = 6'($urandom);
         end
         if (frame == 0 && v == 2 && h == 0) fb_d[0] = 15'h1000;
         if (frame == 1 && $urandom_range(0, 999) == 0) fb_d[1] = 15'($urandom);

         @(negedge clk);

         if (frame == 0 && v == 0) begin
            if (h == 1)   begin chk("p6_0", int'(b6.rgb), 'h3F); chk("a6_0", int'(b6.current_vram_read_addr), 1); end
            if (h == 5)   begin chk("p6_1", int'(b6.rgb), 'h00); chk("a6_1", int'(b6.current_vram_read_addr), 2); end
            if (h == 9)   begin chk("p6_2", int'(b6.rgb), 'h3F); chk("a6_2", int'(b6.current_vram_read_addr), 3); end
            if (h == 13)  begin chk("p6_3", int'(b6.rgb), 'h03); chk("a6_3", int'(b6.current_vram_read_addr), 3); end
            if (h == 800) chk("a6_row0_end", int'(b6.current_vram_read_addr), 150);
            if (h == 1)   begin chk("p2_0", int'(b2.rgb), 'h30); chk("a2_0", int'(b2.current_vram_read_addr), 'h4001); end
            if (h == 3)   chk("p2_1_old_pal", int'(b2.rgb), 'h3F);
            if (h == 5)   chk("p2_2", int'(b2.rgb), 'h0C);
            if (h == 7)   chk("p2_3", int'(b2.rgb), 'h00);
            if (h == 9)   chk("p2_4_new_pal", int'(b2.rgb), 'h15);
            if (h == 200) chk("a2_row0_end", int'(b2.current_vram_read_addr), 'h4019);
         end
         if (frame == 0 && v == 3 && h == 800) chk("a6_line3_end", int'(b6.current_vram_read_addr), 150);
         if (frame == 0 && v == 4 && h == 1)   chk("a6_row1_start", int'(b6.current_vram_read_addr), 151);
         if (frame == 1 && v == 0 && h == 1)   chk("a6_new_base", int'(b6.current_vram_read_addr), 'h1001);
         if ((frame == 1 || frame == 2) && v == 3 && h == 400) begin
            chk("clr_rgb6", int'(b6.rgb), 0);
            chk("clr_addr6", int'(b6.current_vram_read_addr), 0);
            chk("clr_rgb2", int'(b2.rgb), 0);
            chk("clr_addr2", int'(b2.current_vram_read_addr), 0);
         end
         if ((frame == 1 || frame == 2) && v == 4 && h == 1) chk("p6_after_clr", int'(b6.rgb), 'h3F);
         if (frame == 1 && v == 4 && h == 25) chk("p2_pal2_reset", int'(b2.rgb), 'h08);
         if (frame == 2 && v == 4 && h == 25) chk("p2_pal2_kept", int'(b2.rgb), 'h21);

         h++;
         if (h == WL) begin
            h = 0;
            v++;
            if (v == WF) begin
               v = 0;
            end
            if (v == 0) frame++;
         end
      end
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
